// File: rtl/wb_mem_pkg.sv
// ---------------------------------------------------------------------------
// wb_mem_pkg
// Shared definitions for the Wishbone-to-native-bus responder:
//   - bus field widths (WB_DW data bits, WB_SW byte selects)
//   - default request FIFO depth
//   - downstream FSM state encoding
//   - packed payload carried through the request FIFO
//   - helper that turns a request into the native-bus byte strobes
// ---------------------------------------------------------------------------
package wb_mem_pkg;

  localparam int WB_DW         = 32;
  localparam int WB_SW         = 4;
  localparam int DEFAULT_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The word address is kept outside this struct because its width is a
  // parameter of the top level.
  typedef struct packed {
    logic             we;
    logic [WB_DW-1:0] data;
    logic [WB_SW-1:0] sel;
  } req_payload_t;

  // The native bus encodes a read as all-zero strobes.
  function automatic logic [WB_SW-1:0] entry_wstrb(input logic             we,
                                                   input logic [WB_SW-1:0] sel);
    return we ? sel : '0;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// ---------------------------------------------------------------------------
// wb_req_fifo
// Synchronous first-word-fall-through FIFO holding pending Wishbone requests.
// Ports:
//   clk, resetn   clock and synchronous active-low reset
//   flush         drop every stored entry (takes priority over push/pop)
//   push, wdata   write one entry (ignored when full)
//   pop           discard the head entry (ignored when empty)
//   rdata         head entry, valid whenever empty is low
//   full, empty   occupancy flags, derived from the current (pre-pop) count
// ---------------------------------------------------------------------------
module wb_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = storage[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_mem_responder.sv
// ---------------------------------------------------------------------------
// wb_mem_responder
// Pipelined Wishbone B4 slave bridging onto a PicoRV32-style native memory
// bus. Strobes are queued in a small FIFO and issued downstream one at a
// time; each accepted strobe returns exactly one registered ack, in order.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   i_wb_cyc/stb/we/addr/data/sel   Wishbone request side
//   o_wb_stall/ack/data          Wishbone response side
//   mem_valid/wstrb/addr/wdata   native request (wstrb==0 means read)
//   mem_ready/rdata              native completion
// ---------------------------------------------------------------------------
module wb_mem_responder
  import wb_mem_pkg::*;
#(
  parameter int          AW        = 19,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [WB_DW-1:0] i_wb_data,
  input  logic [WB_SW-1:0] i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [WB_DW-1:0] o_wb_data,
  output logic             mem_valid,
  output logic [WB_SW-1:0] mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [WB_DW-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WB_DW-1:0] mem_rdata
);

  localparam int PLW = $bits(req_payload_t);
  localparam int FW  = AW + PLW;

  state_t           state;
  logic             abort;
  logic             ack_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [FW-1:0]    push_entry;
  logic [FW-1:0]    head_entry;
  req_payload_t     push_pl;
  req_payload_t     head_pl;
  logic [AW-1:0]    head_addr;
  logic [WB_SW-1:0] head_wstrb;
  logic             head_null;

  // Stall uses the pre-pop FIFO count, so a full FIFO refuses a strobe even
  // in a cycle where the FSM pops. The abort flag keeps new work out until
  // the withdrawn transaction has fully drained.
  assign o_wb_stall = fifo_full | abort;
  assign push       = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign pop        = i_wb_cyc & ~fifo_empty & (state != REQ);

  assign push_pl    = '{we: i_wb_we, data: i_wb_data, sel: i_wb_sel};
  assign push_entry = {i_wb_addr, push_pl};
  assign {head_addr, head_pl} = head_entry;
  assign head_wstrb = entry_wstrb(head_pl.we, head_pl.sel);
  assign head_null  = head_pl.we & (head_pl.sel == '0);

  // The ack is registered, but a master that drops cyc in the ack cycle has
  // abandoned the bus, so it is masked to never appear outside a cycle.
  assign o_wb_ack = ack_q & i_wb_cyc;

  // Dropping cyc discards everything still queued; an in-flight native
  // transaction is handled by the abort flag instead.
  wb_req_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (~i_wb_cyc),
    .push   (push),
    .wdata  (push_entry),
    .pop    (pop),
    .rdata  (head_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Downstream FSM. IDLE and GAP both pop the FIFO head, so a queued request
  // follows the mandatory one-cycle GAP without an extra IDLE cycle. A null
  // write (we with no byte selects) skips the native bus and is acked
  // straight from the pop. The abort flag is raised when cyc falls during
  // REQ, suppresses that transaction's ack, and clears once GAP is left.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      abort     <= 1'b0;
      ack_q     <= 1'b0;
      o_wb_data <= '0;
      mem_valid <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack_q <= 1'b0;

      if (state == REQ && !i_wb_cyc) begin
        abort <= 1'b1;
      end else if (state == GAP) begin
        abort <= 1'b0;
      end

      case (state)
        IDLE, GAP: begin
          state <= IDLE;
          if (pop) begin
            if (head_null) begin
              ack_q <= 1'b1;
              state <= GAP;
            end else begin
              mem_valid <= 1'b1;
              mem_wstrb <= head_wstrb;
              mem_addr  <= BASE_ADDR + 32'({head_addr, 2'b00});
              mem_wdata <= head_pl.data;
              state     <= REQ;
            end
          end
        end

        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_wstrb == '0) o_wb_data <= mem_rdata;
            ack_q <= i_wb_cyc & ~abort;
            state <= GAP;
          end
        end

        default: begin
          mem_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
